// File: rtl/jtdd_rom_pkg.sv
// Shared constants for the graphics ROM arbiter: requester indices, FSM encoding
// and the default SDRAM word offsets of each ROM region.
package jtdd_rom_pkg;

    localparam logic [1:0] CHAR = 2'd0;
    localparam logic [1:0] SCR  = 2'd1;
    localparam logic [1:0] OBJ  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [21:0] CHAR_OFF_DEF = 22'h00000;
    localparam logic [21:0] SCR_OFF_DEF  = 22'h04000;
    localparam logic [21:0] OBJ_OFF_DEF  = 22'h14000;

    // Round-robin successor: char -> scr -> obj -> char
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == OBJ) ? CHAR : idx + 2'd1;
    endfunction

endpackage

// File: rtl/jtdd_rom_slot.sv
// One-word cache for a single ROM requester: stores the last fetched word,
// compares the word address and picks the addressed byte.
module jtdd_rom_slot #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:1] fill_tag,
    input  logic [15:0]   fill_word,
    output logic [7:0]    data,
    output logic          ok,
    output logic          miss
);

    // Only the word part of the byte address is kept; bit 0 selects the byte.
    logic [AW-1:1] tag;
    logic [15:0]   word;
    logic          valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else if (fill) begin
            tag   <= fill_tag;
            word  <= fill_word;
            valid <= 1'b1;
        end
    end

    assign ok   = cs && valid && (addr[AW-1:1] == tag);
    assign miss = cs && !ok;
    assign data = addr[0] ? word[15:8] : word[7:0];

endmodule

// File: rtl/jtdd_rom_arb.sv
// Shares one SDRAM read port between the char, scroll and obj ROM requesters,
// with a one-word cache per requester and round-robin miss scheduling.
module jtdd_rom_arb
    import jtdd_rom_pkg::*;
#(
    parameter int          CHAR_AW  = 15,
    parameter int          SCR_AW   = 17,
    parameter int          OBJ_AW   = 18,
    parameter logic [21:0] CHAR_OFF = CHAR_OFF_DEF,
    parameter logic [21:0] SCR_OFF  = SCR_OFF_DEF,
    parameter logic [21:0] OBJ_OFF  = OBJ_OFF_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               char_cs,
    input  logic [CHAR_AW-1:0] char_addr,
    output logic [7:0]         char_data,
    output logic               char_ok,
    input  logic               scr_cs,
    input  logic [SCR_AW-1:0]  scr_addr,
    output logic [7:0]         scr_data,
    output logic               scr_ok,
    input  logic               obj_cs,
    input  logic [OBJ_AW-1:0]  obj_addr,
    output logic [7:0]         obj_data,
    output logic               obj_ok,
    output logic [21:0]        sdram_addr,
    output logic               sdram_req,
    input  logic               sdram_ack,
    input  logic               sdram_rdy,
    input  logic [15:0]        sdram_data
);

    localparam int MAX_AW = (CHAR_AW > SCR_AW)
                          ? ((CHAR_AW > OBJ_AW) ? CHAR_AW : OBJ_AW)
                          : ((SCR_AW  > OBJ_AW) ? SCR_AW  : OBJ_AW);
    localparam int TW = MAX_AW - 1;

    // sdram_req/sdram_ack: the request is a level held with a stable address until
    // the one-cycle ack; sdram_rdy is a one-cycle pulse carrying the word.
    logic [1:0]    state;
    logic [1:0]    gnt;
    logic [1:0]    last_grant;
    logic [TW-1:0] ftag;
    logic [2:0]    miss;
    logic          found;
    logic [1:0]    pick;
    logic [1:0]    cand;
    logic [21:0]   pick_addr;
    logic [TW-1:0] pick_tag;
    logic          fill_any;

    // A same-cycle ack+rdy in REQ counts as ack followed by rdy.
    assign fill_any = sdram_rdy && ((state == ST_WAIT) || (state == ST_REQ && sdram_ack));

    always_comb begin
        found = 1'b0;
        pick  = CHAR;
        cand  = last_grant;
        for (int k = 0; k < 3; k++) begin
            cand = rr_next(cand);
            if (!found && miss[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_addr = CHAR_OFF + 22'(char_addr[CHAR_AW-1:1]);
        pick_tag  = TW'(char_addr[CHAR_AW-1:1]);
        case (pick)
            SCR: begin
                pick_addr = SCR_OFF + 22'(scr_addr[SCR_AW-1:1]);
                pick_tag  = TW'(scr_addr[SCR_AW-1:1]);
            end
            OBJ: begin
                pick_addr = OBJ_OFF + 22'(obj_addr[OBJ_AW-1:1]);
                pick_tag  = TW'(obj_addr[OBJ_AW-1:1]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            gnt        <= CHAR;
            last_grant <= OBJ;
            ftag       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (found) begin
                    gnt        <= pick;
                    sdram_addr <= pick_addr;
                    ftag       <= pick_tag;
                    sdram_req  <= 1'b1;
                    state      <= ST_REQ;
                end
                ST_REQ: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    if (sdram_rdy) begin
                        last_grant <= gnt;
                        state      <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: if (sdram_rdy) begin
                    last_grant <= gnt;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    jtdd_rom_slot #(.AW(CHAR_AW)) u_char (
        .clk(clk), .rst(rst), .cs(char_cs), .addr(char_addr),
        .fill(fill_any && gnt == CHAR), .fill_tag(ftag[CHAR_AW-2:0]), .fill_word(sdram_data),
        .data(char_data), .ok(char_ok), .miss(miss[CHAR])
    );

    jtdd_rom_slot #(.AW(SCR_AW)) u_scr (
        .clk(clk), .rst(rst), .cs(scr_cs), .addr(scr_addr),
        .fill(fill_any && gnt == SCR), .fill_tag(ftag[SCR_AW-2:0]), .fill_word(sdram_data),
        .data(scr_data), .ok(scr_ok), .miss(miss[SCR])
    );

    jtdd_rom_slot #(.AW(OBJ_AW)) u_obj (
        .clk(clk), .rst(rst), .cs(obj_cs), .addr(obj_addr),
        .fill(fill_any && gnt == OBJ), .fill_tag(ftag[OBJ_AW-2:0]), .fill_word(sdram_data),
        .data(obj_data), .ok(obj_ok), .miss(miss[OBJ])
    );

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Directed bench for the graphics ROM arbiter: cache hits, round-robin order,
// address arithmetic with wrap, in-flight address change, ack+rdy overlap, reset abort.
module tb_jtdd_rom_arb;

    logic        clk;
    logic        rst;
    logic        char_cs;
    logic [14:0] char_addr;
    logic [7:0]  char_data;
    logic        char_ok;
    logic        scr_cs;
    logic [16:0] scr_addr;
    logic [7:0]  scr_data;
    logic        scr_ok;
    logic        obj_cs;
    logic [17:0] obj_addr;
    logic [7:0]  obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_data;

    int checks = 0;
    int errors = 0;

    jtdd_rom_arb #(
        .CHAR_AW(15), .SCR_AW(17), .OBJ_AW(18),
        .CHAR_OFF(22'h00000), .SCR_OFF(22'h04000), .OBJ_OFF(22'h3FFFFF)
    ) dut (
        .clk(clk), .rst(rst),
        .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_data(sdram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [21:0] exp_addr);
        int n = 0;
        while (!sdram_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(sdram_req), 32'd1);
        check({tag, "_addr"}, 32'(sdram_addr), 32'(exp_addr));
    endtask

    task automatic pulse_ack();
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    task automatic pulse_rdy(input logic [15:0] d);
        sdram_rdy  = 1'b1;
        sdram_data = d;
        @(negedge clk);
        sdram_rdy  = 1'b0;
        sdram_data = 16'h0000;
    endtask

    task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [15:0] d);
        wait_req(tag, exp_addr);
        pulse_ack();
        @(negedge clk);
        check({tag, "_req_low"}, 32'(sdram_req), 32'd0);
        pulse_rdy(d);
    endtask

    initial begin
        rst = 1'b1;
        char_cs = 1'b0; char_addr = '0;
        scr_cs = 1'b0;  scr_addr = '0;
        obj_cs = 1'b0;  obj_addr = '0;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_data = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_char_ok", 32'(char_ok), 32'd0);
        check("rst_char_data", 32'(char_data), 32'd0);
        check("rst_obj_data", 32'(obj_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic fill and byte select
        char_cs = 1'b1; char_addr = 15'h0003;
        wait_req("t1", 22'h00001);
        pulse_ack();
        @(negedge clk);
        sdram_rdy = 1'b1; sdram_data = 16'hA55A;
        check("t1_ok_pre", 32'(char_ok), 32'd0);
        @(negedge clk);
        sdram_rdy = 1'b0;
        check("t1_ok", 32'(char_ok), 32'd1);
        check("t1_data_hi", 32'(char_data), 32'hA5);
        char_addr = 15'h0002;
        #1;
        check("t1_data_lo", 32'(char_data), 32'h5A);
        check("t1_ok_lo", 32'(char_ok), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_no_req", 32'(sdram_req), 32'd0);

        // Reset, then all three miss at once
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        char_addr = 15'h0010; scr_cs = 1'b1; scr_addr = 17'h00010;
        obj_cs = 1'b1; obj_addr = 18'h3FFFF;
        serve("r1_char", 22'h000008, 16'hA1B2);
        serve("r1_scr", 22'h004008, 16'hC3D4);
        serve("r1_obj", 22'h01FFFE, 16'hE5F6);
        check("r1_char_data", 32'(char_data), 32'hB2);
        check("r1_scr_data", 32'(scr_data), 32'hD4);
        check("r1_obj_data", 32'(obj_data), 32'hE5);
        check("r1_oks", 32'({char_ok, scr_ok, obj_ok}), 32'h7);

        // Second round restarts at char
        char_addr = 15'h0020; scr_addr = 17'h00020; obj_addr = 18'h00000;
        serve("r2_char", 22'h000010, 16'h0102);
        serve("r2_scr", 22'h004010, 16'h0304);
        serve("r2_obj", 22'h3FFFFF, 16'h0506);
        check("r2_oks", 32'({char_ok, scr_ok, obj_ok}), 32'h7);
        check("r2_obj_data", 32'(obj_data), 32'h06);

        // Char keeps missing; scr and obj still get their turns
        char_addr = 15'h0040; scr_addr = 17'h00040;
        serve("r3_char", 22'h000020, 16'h0708);
        char_addr = 15'h0060; obj_addr = 18'h00002;
        serve("r3_scr", 22'h004020, 16'h090A);
        serve("r3_obj", 22'h000000, 16'h0B0C);
        serve("r3_char2", 22'h000030, 16'h0D0E);
        check("r3_oks", 32'({char_ok, scr_ok, obj_ok}), 32'h7);
        check("r3_obj_data", 32'(obj_data), 32'h0C);
        check("r3_char_data", 32'(char_data), 32'h0E);

        // Address changes while the fetch is in flight
        char_addr = 15'h0100;
        wait_req("t4", 22'h000080);
        pulse_ack();
        char_addr = 15'h0200;
        @(negedge clk);
        pulse_rdy(16'hAAAA);
        check("t4_ok_stale", 32'(char_ok), 32'd0);
        serve("t4_refetch", 22'h000100, 16'h5566);
        check("t4_ok", 32'(char_ok), 32'd1);
        check("t4_data", 32'(char_data), 32'h66);

        // ack and rdy together in the first REQ cycle
        char_addr = 15'h0300;
        wait_req("t5", 22'h000180);
        sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_data = 16'h1234;
        @(negedge clk);
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_data = 16'h0000;
        check("t5_ok", 32'(char_ok), 32'd1);
        check("t5_data", 32'(char_data), 32'h34);
        check("t5_req", 32'(sdram_req), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_req_idle", 32'(sdram_req), 32'd0);

        // Deselect keeps the cached word
        scr_cs = 1'b0;
        #1;
        check("cs_off_ok", 32'(scr_ok), 32'd0);
        @(negedge clk);
        scr_cs = 1'b1;
        #1;
        check("cs_on_ok", 32'(scr_ok), 32'd1);
        check("cs_on_data", 32'(scr_data), 32'h0A);
        repeat (2) @(negedge clk);
        check("cs_on_no_req", 32'(sdram_req), 32'd0);

        // Reset while waiting for rdy, then a stray rdy
        char_addr = 15'h0400;
        wait_req("t6", 22'h000200);
        pulse_ack();
        char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(sdram_req), 32'd0);
        check("t6_rst_addr", 32'(sdram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse_rdy(16'hBEEF);
        check("t6_char_data", 32'(char_data), 32'd0);
        check("t6_req", 32'(sdram_req), 32'd0);
        char_cs = 1'b1; scr_cs = 1'b1;
        #1;
        check("t6_oks", 32'({char_ok, scr_ok, obj_ok}), 32'd0);
        serve("t6_char", 22'h000200, 16'h7788);
        check("t6_char_ok", 32'(char_ok), 32'd1);
        check("t6_char_byte", 32'(char_data), 32'h88);
        serve("t6_scr", 22'h004020, 16'h99AA);
        check("t6_scr_byte", 32'(scr_data), 32'hAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
